t01_drop_timer: RTL

Gravity timer for the team_01 falling-block game: turns the 25-bit `scoremod` speed-up value from the speed controller into a periodic piece-drop request. It sits between the speed controller and the game FSM. It derives the drop period from a base period minus `scoremod`, clamped to a floor, with a faster soft-drop override. It raises `drop_req` each period and holds it until the game FSM acknowledges it. A sticky flag reports a missed period.

---
 rtl/t01_drop_timer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/t01_drop_timer.sv
// Gravity timer: turns the speed controller's scoremod into a periodic drop request
// that is held until the game FSM acknowledges it, with a sticky missed-period flag.
//
// state | meaning
// IDLE  | no piece in play, cnt held at 0, no request
// COUNT | counting towards the next drop
// REQ   | drop_req pending, still counting the following period
module t01_drop_timer #(
    parameter int unsigned BASE_PERIOD    = 25000000,
    parameter int unsigned MIN_PERIOD     = 2500000,
    parameter int unsigned SOFT_PERIOD    = 2500000,
    parameter int unsigned GAMEOVER_STATE = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  gamestate,
    input  logic        active,
    input  logic        pause,
    input  logic        soft_drop,
    input  logic [24:0] scoremod,
    input  logic        drop_ack,
    output logic        drop_req,
    output logic        overrun,
    output logic [24:0] period
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        REQ   = 2'd2
    } state_t;

    localparam logic [24:0] BASE_P = 25'(BASE_PERIOD);
    localparam logic [24:0] MIN_P  = 25'(MIN_PERIOD);
    localparam logic [24:0] SOFT_P = 25'(SOFT_PERIOD);
    localparam logic [24:0] SPAN   = BASE_P - MIN_P;
    localparam logic [3:0]  GO_ST  = 4'(GAMEOVER_STATE);

    state_t      state_q;
    logic [24:0] cnt_q;
    logic [24:0] period_q;
    logic [24:0] period_d;
    logic [24:0] gravity;
    logic        drop_req_q;
    logic        overrun_q;
    logic        terminal;

    // Compare against the span first so a large scoremod never wraps the subtraction.
    always_comb begin
        gravity  = (scoremod >= SPAN) ? MIN_P : (BASE_P - scoremod);
        period_d = gravity;
        if (soft_drop && (SOFT_P < gravity)) begin
            period_d = SOFT_P;
        end
    end

    // >= rather than == so a period that shrinks below the running count fires at once.
    assign terminal = (cnt_q >= (period_q - 25'd1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            drop_req_q <= 1'b0;
            overrun_q  <= 1'b0;
            period_q   <= BASE_P;
        end else if (gamestate == GO_ST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            drop_req_q <= 1'b0;
            overrun_q  <= 1'b0;
            period_q   <= BASE_P;
        end else begin
            period_q <= period_d;
            if (!active) begin
                state_q    <= IDLE;
                cnt_q      <= '0;
                drop_req_q <= 1'b0;
            end else if (pause) begin
                if ((state_q == REQ) && drop_ack) begin
                    drop_req_q <= 1'b0;
                    state_q    <= COUNT;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        cnt_q   <= '0;
                        state_q <= COUNT;
                    end
                    COUNT: begin
                        if (terminal) begin
                            cnt_q      <= '0;
                            drop_req_q <= 1'b1;
                            state_q    <= REQ;
                        end else begin
                            cnt_q <= cnt_q + 25'd1;
                        end
                    end
                    REQ: begin
                        if (terminal) begin
                            cnt_q     <= '0;
                            overrun_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 25'd1;
                        end
                        if (drop_ack) begin
                            drop_req_q <= 1'b0;
                            state_q    <= COUNT;
                        end
                    end
                    default: begin
                        state_q    <= IDLE;
                        cnt_q      <= '0;
                        drop_req_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign drop_req = drop_req_q;
    assign overrun  = overrun_q;
    assign period   = period_q;

endmodule
